// File: rtl/delay_ctrl_requester.sv
// delay_ctrl_requester: turns two raw push-buttons into debounced, auto-repeating
// single-cycle slower/faster request pulses for the delay_ctrl conduit, and turns
// the returned delay value into a blink tick and LED.
// Key index 0 is "slower", key index 1 is "faster".
module delay_ctrl_requester #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 25000000,
    parameter int TICK_BASE       = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_slower_n,
    input  logic       key_faster_n,
    input  logic [3:0] delay,
    output logic       delay_slower,
    output logic       delay_faster,
    output logic       tick,
    output logic       led
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam int TW = $clog2(16 * TICK_BASE + 1);

    logic [1:0] key_n;
    logic [1:0] pressed;
    logic [1:0] req;

    assign key_n = {key_faster_n, key_slower_n};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            logic          sync1_q;
            logic          sync2_q;
            logic          pressed_q;
            logic          pressed_prev_q;
            logic [DW-1:0] deb_cnt_q;
            logic [RW-1:0] rep_cnt_q;
            logic          alone;
            logic          new_press;
            logic          rep_fire;

            // Two-flop synchronizer; idles at the released (high) level.
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                end else begin
                    sync1_q <= key_n[gi];
                    sync2_q <= sync1_q;
                end
            end

            // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pressed_q <= 1'b0;
                    deb_cnt_q <= '0;
                end else if (~sync2_q == pressed_q) begin
                    deb_cnt_q <= '0;
                end else if (deb_cnt_q == DW'(DEBOUNCE_CYCLES)) begin
                    pressed_q <= ~sync2_q;
                    deb_cnt_q <= '0;
                end else begin
                    deb_cnt_q <= deb_cnt_q + DW'(1);
                end
            end

            // Previous debounced state, used to find the released->pressed edge.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pressed_prev_q <= 1'b0;
                end else begin
                    pressed_prev_q <= pressed_q;
                end
            end

            // A key only generates requests while it is the sole pressed key.
            assign alone     = pressed_q & ~pressed[1-gi];
            assign new_press = pressed_q & ~pressed_prev_q;
            assign rep_fire  = (rep_cnt_q == RW'(REPEAT_CYCLES - 1));

            // Repeat timer: held at 0 unless alone; restarts on every request so
            // requests are spaced REPEAT_CYCLES apart. Limit drops do not touch it.
            always_ff @(posedge clk) begin
                if (reset || !alone || new_press || rep_fire) begin
                    rep_cnt_q <= '0;
                end else begin
                    rep_cnt_q <= rep_cnt_q + RW'(1);
                end
            end

            assign req[gi]     = alone & (new_press | rep_fire);
            assign pressed[gi] = pressed_q;
        end
    endgenerate

    logic delay_slower_q;
    logic delay_faster_q;

    // Registered request pulses; simultaneous requests cancel, limits drop requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            delay_slower_q <= 1'b0;
            delay_faster_q <= 1'b0;
        end else begin
            delay_slower_q <= req[0] & ~req[1] & (delay != 4'd15);
            delay_faster_q <= req[1] & ~req[0] & (delay != 4'd0);
        end
    end

    assign delay_slower = delay_slower_q;
    assign delay_faster = delay_faster_q;

    logic [TW-1:0] tick_cnt_q;
    logic [TW-1:0] tick_term;
    logic          load_pending_q;
    logic          tick_q;
    logic          led_q;

    // Terminal count for the period, (delay+1)*TICK_BASE-1, unsigned.
    assign tick_term = (TW'({1'b0, delay}) + TW'(1)) * TW'(TICK_BASE) - TW'(1);

    // Blink period counter: first load right after reset, then count down and
    // reload at zero, sampling delay only at each (re)load.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q     <= '0;
            load_pending_q <= 1'b1;
            tick_q         <= 1'b0;
            led_q          <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (load_pending_q) begin
                tick_cnt_q     <= tick_term;
                load_pending_q <= 1'b0;
            end else if (tick_cnt_q == '0) begin
                tick_q     <= 1'b1;
                led_q      <= ~led_q;
                tick_cnt_q <= tick_term;
            end else begin
                tick_cnt_q <= tick_cnt_q - TW'(1);
            end
        end
    end

    assign tick = tick_q;
    assign led  = led_q;

endmodule

// File: tb/tb_delay_ctrl_requester.sv
// Testbench for delay_ctrl_requester with small parameters.
// Expected pulses/ticks are queued when stimulus is applied and popped by a
// negedge monitor when the DUT produces them.
module tb_delay_ctrl_requester;

    localparam int D  = 4;
    localparam int R  = 20;
    localparam int TB = 3;

    logic       clk;
    logic       reset;
    logic       key_slower_n;
    logic       key_faster_n;
    logic [3:0] delay;
    logic       delay_slower;
    logic       delay_faster;
    logic       tick;
    logic       led;

    delay_ctrl_requester #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_CYCLES  (R),
        .TICK_BASE      (TB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_slower_n(key_slower_n),
        .key_faster_n(key_faster_n),
        .delay       (delay),
        .delay_slower(delay_slower),
        .delay_faster(delay_faster),
        .tick        (tick),
        .led         (led)
    );

    typedef struct {
        int   cyc;
        logic kind;   // pulses: 0 = slower, 1 = faster
        logic led;    // ticks: led level after the tick
    } exp_t;

    typedef struct {
        string      name;
        logic       ks;
        logic       kf;
        logic [3:0] dly;
        int         hold;
        int         n_slow;
        int         n_fast;
    } vec_t;

    exp_t pulse_q[$];
    exp_t tick_q[$];
    int   cyc;
    int   n_pass;
    int   n_total;
    logic tick_en;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_pulse(input logic kind, input int c);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        e.led  = 1'b0;
        pulse_q.push_back(e);
    endtask

    task automatic push_tick(input int c, input logic l);
        exp_t e;
        e.cyc  = c;
        e.kind = 1'b0;
        e.led  = l;
        tick_q.push_back(e);
    endtask

    // Monitor: pop and compare whenever the DUT emits a pulse or tick.
    always @(negedge clk) begin
        exp_t e;
        if (delay_slower || delay_faster) begin
            check("exclusive_outputs", int'(delay_slower & delay_faster), 0);
            if (pulse_q.size() == 0) begin
                check("unexpected_pulse_cycle", cyc, -1);
            end else begin
                e = pulse_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_kind", int'(delay_faster), int'(e.kind));
            end
        end
        if (tick_en && tick) begin
            if (tick_q.size() == 0) begin
                check("unexpected_tick_cycle", cyc, -1);
            end else begin
                e = tick_q.pop_front();
                check("tick_cycle", cyc, e.cyc);
                check("tick_led", int'(led), int'(e.led));
            end
        end
    end

    task automatic end_scenario(input string name);
        check({"missing_pulses_", name}, pulse_q.size(), 0);
        pulse_q.delete();
    endtask

    vec_t vecs[8];

    initial begin
        int p;
        int r;
        int l;

        vecs[0] = '{"slow_single",   1'b1, 1'b0, 4'd5,  8,  1, 0};
        vecs[1] = '{"slow_repeat",   1'b1, 1'b0, 4'd3,  70, 4, 0};
        vecs[2] = '{"fast_repeat",   1'b0, 1'b1, 4'd5,  30, 0, 2};
        vecs[3] = '{"both_held",     1'b1, 1'b1, 4'd5,  50, 0, 0};
        vecs[4] = '{"slow_at_max",   1'b1, 1'b0, 4'd15, 8,  0, 0};
        vecs[5] = '{"fast_at_min",   1'b0, 1'b1, 4'd0,  8,  0, 0};
        vecs[6] = '{"slow_at_min",   1'b1, 1'b0, 4'd0,  8,  1, 0};
        vecs[7] = '{"fast_at_max",   1'b0, 1'b1, 4'd15, 8,  0, 1};

        n_pass       = 0;
        n_total      = 0;
        tick_en      = 1'b0;
        reset        = 1'b1;
        key_slower_n = 1'b1;
        key_faster_n = 1'b1;
        delay        = 4'd0;
        step(3);

        // Reset state
        check("reset_delay_slower", int'(delay_slower), 0);
        check("reset_delay_faster", int'(delay_faster), 0);
        check("reset_tick", int'(tick), 0);
        check("reset_led", int'(led), 0);

        // Tick: delay=0 -> period 3; then delay=2 mid-period -> period 9; then reset.
        tick_en = 1'b1;
        reset   = 1'b0;
        l = cyc + 1;                  // first load edge
        push_tick(l + 3, 1'b1);
        push_tick(l + 6, 1'b0);
        push_tick(l + 9, 1'b1);
        push_tick(l + 12, 1'b0);      // period in progress when delay changes
        push_tick(l + 21, 1'b1);
        step(11);                     // cyc = l+10
        delay = 4'd2;
        step(14);                     // cyc = l+24
        check("ticks_before_reset", tick_q.size(), 0);
        reset = 1'b1;
        step(1);                      // reset sampled at edge l+25
        check("tick_after_reset", int'(tick), 0);
        check("led_after_reset", int'(led), 0);
        reset = 1'b0;
        push_tick(cyc + 1 + 9, 1'b1); // reload at next edge with delay=2
        step(12);
        check("ticks_after_reset", tick_q.size(), 0);
        tick_en = 1'b0;
        tick_q.delete();
        step(5);

        // Table-driven press scenarios
        for (int i = 0; i < 8; i++) begin
            delay = vecs[i].dly;
            step(1);
            p = cyc + 1;
            key_slower_n = ~vecs[i].ks;
            key_faster_n = ~vecs[i].kf;
            for (int k = 0; k < vecs[i].n_slow; k++) push_pulse(1'b0, p + D + 3 + k * R);
            for (int k = 0; k < vecs[i].n_fast; k++) push_pulse(1'b1, p + D + 3 + k * R);
            step(vecs[i].hold);
            key_slower_n = 1'b1;
            key_faster_n = 1'b1;
            step(30);
            end_scenario(vecs[i].name);
        end

        // Bouncing faster key, then a steady press
        delay = 4'd5;
        for (int i = 0; i < 12; i++) begin
            key_faster_n = ((i / 2) % 2) == 1;
            step(1);
        end
        p = cyc + 1;
        key_faster_n = 1'b0;
        push_pulse(1'b1, p + 7);
        step(15);
        key_faster_n = 1'b1;
        step(30);
        end_scenario("bounce");

        // Both held, then faster released: slower restarts its repeat timer
        p = cyc + 1;
        key_slower_n = 1'b0;
        key_faster_n = 1'b0;
        step(50);
        r = cyc + 1;                  // first edge sampling faster released
        key_faster_n = 1'b1;
        push_pulse(1'b0, r + 2 + D + R);
        step(25);
        key_slower_n = 1'b1;
        step(30);
        end_scenario("both_then_release");

        // Reset in the middle of a debounce restarts it from the raw level
        p = cyc + 1;
        key_slower_n = 1'b0;
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        push_pulse(1'b0, cyc + 1 + D + 3);
        step(15);
        key_slower_n = 1'b1;
        step(30);
        end_scenario("reset_mid_debounce");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
